// File: rtl/raytrace_pkg.sv
// Shared ray-tracing types: Q16.16 signed fixed point and the closest-hit FSM states.
package raytrace_pkg;

    typedef logic signed [31:0] fixed_t;

    localparam int FRAC_BITS = 16;
    localparam fixed_t T_INF = 32'sh7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } hit_state_e;

endpackage

// File: rtl/closest_hit.sv
// Tracks the nearest intersection (smallest signed t) over a ray's responses and
// reports a registered result with a one-cycle o_valid pulse.
module closest_hit
    import raytrace_pkg::*;
#(
    parameter int     TRI_W = 16,
    parameter fixed_t T_MAX = T_INF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [TRI_W-1:0] i_num_tri,
    input  logic             i_valid,
    input  logic             i_result,
    input  logic [31:0]      i_t,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_hit,
    output logic [31:0]      o_t,
    output logic [TRI_W-1:0] o_tri_id
);

    // Handshake: i_valid is accepted on every rising edge while in ACCUM; there is
    // no ready, and o_valid is a single-cycle pulse with no backpressure.

    hit_state_e       state_q, state_d;
    logic [TRI_W-1:0] remaining_q, remaining_d;
    logic [TRI_W-1:0] idx_q, idx_d;
    fixed_t           best_t_q, best_t_d;
    logic             best_hit_q, best_hit_d;
    logic [TRI_W-1:0] best_id_q, best_id_d;
    logic             out_hit_q, out_hit_d;
    fixed_t           out_t_q, out_t_d;
    logic [TRI_W-1:0] out_id_q, out_id_d;

    fixed_t t_in;
    logic   closer;

    assign t_in   = fixed_t'(i_t);
    assign closer = t_in < best_t_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            idx_q       <= '0;
            best_t_q    <= T_MAX;
            best_hit_q  <= 1'b0;
            best_id_q   <= '0;
            out_hit_q   <= 1'b0;
            out_t_q     <= T_MAX;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            best_t_q    <= best_t_d;
            best_hit_q  <= best_hit_d;
            best_id_q   <= best_id_d;
            out_hit_q   <= out_hit_d;
            out_t_q     <= out_t_d;
            out_id_q    <= out_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        best_t_d    = best_t_q;
        best_hit_d  = best_hit_q;
        best_id_d   = best_id_q;
        out_hit_d   = out_hit_q;
        out_t_d     = out_t_q;
        out_id_d    = out_id_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    remaining_d = i_num_tri;
                    idx_d       = '0;
                    best_t_d    = T_MAX;
                    best_hit_d  = 1'b0;
                    best_id_d   = '0;
                    if (i_num_tri != '0) begin
                        state_d = ACCUM;
                    end else begin
                        // Empty ray: publish the no-hit result so it is visible with the pulse.
                        state_d   = DONE;
                        out_hit_d = 1'b0;
                        out_t_d   = T_MAX;
                        out_id_d  = '0;
                    end
                end
            end
            ACCUM: begin
                if (i_valid) begin
                    if (i_result && closer) begin
                        best_t_d   = t_in;
                        best_id_d  = idx_q;
                        best_hit_d = 1'b1;
                    end
                    idx_d       = idx_q + TRI_W'(1);
                    remaining_d = remaining_q - TRI_W'(1);
                    if (remaining_q == TRI_W'(1)) begin
                        // Output registers load on entry to DONE so data and o_valid align.
                        state_d   = DONE;
                        out_hit_d = best_hit_d;
                        out_t_d   = best_t_d;
                        out_id_d  = best_id_d;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state_q == ACCUM);
        o_valid  = (state_q == DONE);
        o_hit    = out_hit_q;
        o_t      = out_t_q;
        o_tri_id = out_id_q;
    end

endmodule

// File: tb/tb_closest_hit.sv
// Directed bench for closest_hit: a table of rays with hand-computed nearest hits,
// plus hand-written sequences for zero count, ignored inputs and reset mid-ray.
module tb_closest_hit;

  localparam int TRI_W = 16;
  localparam logic [31:0] T_MAX = 32'h7FFF_FFFF;

  logic             clk;
  logic             rst;
  logic             start;
  logic [TRI_W-1:0] num_tri;
  logic             valid;
  logic             result;
  logic [31:0]      t_in;
  logic             busy;
  logic             o_valid;
  logic             hit;
  logic [31:0]      t_out;
  logic [TRI_W-1:0] tri_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        res;
    logic [31:0] t;
  } rsp_t;

  typedef struct {
    int          first;
    int          n;
    int          gap;
    logic        exp_hit;
    logic [31:0] exp_t;
    logic [15:0] exp_id;
  } ray_t;

  rsp_t rsp[$];
  ray_t rays[$];
  logic [31:0] exp_q[$];

  closest_hit #(.TRI_W(TRI_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_num_tri (num_tri),
    .i_valid   (valid),
    .i_result  (result),
    .i_t       (t_in),
    .o_busy    (busy),
    .o_valid   (o_valid),
    .o_hit     (hit),
    .o_t       (t_out),
    .o_tri_id  (tri_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic eh, input logic [31:0] et,
                              input logic [15:0] eid);
    logic [31:0] sb_t;
    check({tag, " o_valid"}, 32'(o_valid), 32'd1);
    check({tag, " o_busy@valid"}, 32'(busy), 32'd0);
    check({tag, " o_hit"}, 32'(hit), 32'(eh));
    check({tag, " o_tri_id"}, 32'(tri_id), 32'(eid));
    if (exp_q.size() > 0) begin
      sb_t = exp_q.pop_front();
      check({tag, " o_t"}, t_out, sb_t);
    end else begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end
    check({tag, " t_table"}, t_out, et);
  endtask

  // driver tasks
  task automatic add_ray(input int n, input int gap, input logic eh, input logic [31:0] et,
                         input logic [15:0] eid);
    ray_t r;
    r.first = rsp.size();
    r.n = n;
    r.gap = gap;
    r.exp_hit = eh;
    r.exp_t = et;
    r.exp_id = eid;
    rays.push_back(r);
  endtask

  task automatic add_rsp(input logic res, input logic [31:0] t);
    rsp_t x;
    x.res = res;
    x.t = t;
    rsp.push_back(x);
  endtask

  task automatic run_ray(input ray_t r, input logic noisy_start, input string tag);
    exp_q.push_back(r.exp_t);
    start = 1'b1;
    num_tri = TRI_W'(r.n);
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    for (int k = 0; k < r.n; k++) begin
      valid = 1'b1;
      result = rsp[r.first + k].res;
      t_in = rsp[r.first + k].t;
      if (noisy_start) begin
        start = 1'b1;
        num_tri = TRI_W'(7);
      end
      tick();
      valid = 1'b0;
      start = 1'b0;
      t_in = 32'h0;
      result = 1'b0;
      if (k < r.n - 1) begin
        if (o_valid) check({tag, " early o_valid"}, 32'(o_valid), 32'd0);
        for (int g = 0; g < r.gap; g++) begin
          tick();
          check({tag, " o_valid in gap"}, 32'(o_valid), 32'd0);
        end
      end
    end
    check_result(tag, r.exp_hit, r.exp_t, r.exp_id);
    tick();
    check({tag, " pulse width"}, 32'(o_valid), 32'd0);
    check({tag, " hold t"}, t_out, r.exp_t);
  endtask

  initial begin
    ray_t r;
    rst = 1'b1;
    start = 1'b0;
    num_tri = '0;
    valid = 1'b0;
    result = 1'b0;
    t_in = 32'h0;

    // vector table: responses then expected nearest hit
    add_ray(1, 0, 1'b1, 32'd180224, 16'd0);
    add_rsp(1'b1, 32'd180224);
    add_ray(4, 0, 1'b1, 32'h0003_0000, 16'd2);
    add_rsp(1'b1, 32'h0005_0000); add_rsp(1'b0, 32'h0000_1000);
    add_rsp(1'b1, 32'h0003_0000); add_rsp(1'b1, 32'h0004_0000);
    add_ray(3, 0, 1'b1, 32'h0002_0000, 16'd0);
    add_rsp(1'b1, 32'h0002_0000); add_rsp(1'b1, 32'h0002_0000); add_rsp(1'b0, 32'h0);
    add_ray(3, 0, 1'b0, T_MAX, 16'd0);
    add_rsp(1'b0, 32'h0001_0000); add_rsp(1'b0, 32'h0); add_rsp(1'b0, 32'h8000_0000);
    add_ray(4, 2, 1'b1, 32'h0003_0000, 16'd2);
    add_rsp(1'b1, 32'h0005_0000); add_rsp(1'b0, 32'h0000_1000);
    add_rsp(1'b1, 32'h0003_0000); add_rsp(1'b1, 32'h0004_0000);
    add_ray(3, 0, 1'b1, 32'hFFFF_8000, 16'd1);
    add_rsp(1'b1, 32'h0001_0000); add_rsp(1'b1, 32'hFFFF_8000); add_rsp(1'b1, 32'h7FFF_FFFF);
    add_ray(2, 1, 1'b0, T_MAX, 16'd0);
    add_rsp(1'b1, 32'h7FFF_FFFF); add_rsp(1'b0, 32'h0);
    add_ray(5, 0, 1'b1, 32'h0001_0000, 16'd4);
    add_rsp(1'b1, 32'h0005_0000); add_rsp(1'b1, 32'h0004_0000); add_rsp(1'b1, 32'h0003_0000);
    add_rsp(1'b1, 32'h0002_0000); add_rsp(1'b1, 32'h0001_0000);

    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(o_valid), 32'd0);
    check("reset hit", 32'(hit), 32'd0);
    check("reset t", t_out, T_MAX);
    check("reset tri_id", 32'(tri_id), 32'd0);

    for (int i = 0; i < rays.size(); i++) begin
      run_ray(rays[i], 1'b0, $sformatf("vec%0d", i));
    end

    // start during ACCUM must not reload the count
    run_ray(rays[1], 1'b1, "noisy_start");

    // zero-count ray
    exp_q.push_back(T_MAX);
    start = 1'b1;
    num_tri = '0;
    tick();
    start = 1'b0;
    check_result("zero", 1'b0, T_MAX, 16'd0);
    tick();
    check("zero pulse width", 32'(o_valid), 32'd0);
    check("zero busy after", 32'(busy), 32'd0);

    // i_valid in IDLE is ignored
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1;
      result = 1'b1;
      t_in = 32'h0;
      tick();
      check("idle valid busy", 32'(busy), 32'd0);
      check("idle valid o_valid", 32'(o_valid), 32'd0);
    end
    valid = 1'b0;
    result = 1'b0;
    run_ray(rays[0], 1'b0, "after_idle_valid");

    // reset after 2 of 5 responses
    start = 1'b1;
    num_tri = TRI_W'(5);
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid = 1'b1;
      result = 1'b1;
      t_in = 32'h0000_0100;
      tick();
    end
    valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst valid", 32'(o_valid), 32'd0);
    check("midrst hit", 32'(hit), 32'd0);
    check("midrst t", t_out, T_MAX);
    check("midrst tri_id", 32'(tri_id), 32'd0);
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      result = 1'b1;
      t_in = 32'h0000_0100;
      tick();
      check("midrst no o_valid", 32'(o_valid), 32'd0);
    end
    valid = 1'b0;
    result = 1'b0;
    r = rays[7];
    run_ray(r, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/closest_hit.md
# closest_hit

Downstream consumer of the ray–triangle `intersection` stage. For one ray, it accepts one intersection response per triangle tested and tracks the nearest hit (smallest `t`) and the index of that triangle. It reports a single registered result once all expected responses have arrived. It sits between the intersection pipeline and the shading/framebuffer write stage.

## Interface

**Parameters**
- `TRI_W`, default 16: width of the triangle count and triangle index.
- `T_MAX`, default `32'sh7FFF_FFFF`: the `t` value reported when there is no hit (Q16.16 "infinity").

**Ports**
- `i_clk` — in — 1 — clock; all logic on the rising edge.
- `i_rst` — in — 1 — synchronous reset, active-high.
- `i_start` — in — 1 — begin a new ray; samples `i_num_tri`.
- `i_num_tri` — in — `TRI_W` — number of intersection responses expected for this ray.
- `i_valid` — in — 1 — an intersection response is present (driven from intersection `o_valid`).
- `i_result` — in — 1 — the ray hits this triangle (from `o_result`).
- `i_t` — in — 32 — signed Q16.16 hit distance (from `o_t`); meaningful only when `i_result`=1.
- `o_busy` — out — 1 — a ray is being accumulated.
- `o_valid` — out — 1 — one-cycle pulse: the ray result is ready.
- `o_hit` — out — 1 — at least one response had `i_result`=1.
- `o_t` — out — 32 — signed Q16.16 nearest `t`, or `T_MAX` when there is no hit.
- `o_tri_id` — out — `TRI_W` — index (arrival order, 0-based) of the nearest-hit triangle; 0 when there is no hit.

## Operation

**States:** `IDLE`, `ACCUM`, `DONE`.

**IDLE**
- `i_start`=1 latches `i_num_tri` into `remaining`, and sets `best_t`=`T_MAX`, `best_hit`=0, `best_id`=0, `idx`=0.
- If `i_num_tri`≠0, go to `ACCUM`; otherwise go to `DONE`.
- `i_valid` in `IDLE` is ignored.

**ACCUM**
- On each `i_valid`=1:
  - If `i_result`=1 and `i_t` < `best_t` (signed compare), update `best_t`=`i_t`, `best_id`=`idx`, `best_hit`=1.
  - Increment `idx`; decrement `remaining`.
  - When `remaining` goes 1→0, go to `DONE`.
- **Ties:** a strict `<` comparison means the earlier triangle wins on equal `t`.
- `i_start` in `ACCUM` is ignored. No abort path exists other than `i_rst`.

**DONE** (lasts 1 cycle)
- Drive `o_valid`=1 and copy `best_*` into `o_hit`/`o_t`/`o_tri_id`, then go to `IDLE`.
- `i_start` and `i_valid` arriving in `DONE` are ignored.

**Data rules**
- Responses arrive in issue order, so the arrival index equals the triangle index.
- `t` is never rescaled or saturated; the full 32-bit signed value is compared.
- `idx` wraps at 2^`TRI_W`; this is unreachable because `i_num_tri` < 2^`TRI_W`.

## Timing

- **Reset values:** `o_busy`=0, `o_valid`=0, `o_hit`=0, `o_t`=`T_MAX`, `o_tri_id`=0; state is `IDLE`.
- **Reset mid-ray:** a reset during `ACCUM` discards partial results, and no `o_valid` is produced.
- **`o_busy`:**
  - Goes 1 in the cycle after an accepted `i_start` with nonzero count.
  - Goes 0 in the cycle `o_valid` is asserted.
  - Stays 0 for a zero-count ray.
- **Result latency:**
  - `o_valid` is asserted exactly 1 cycle after the cycle of the last accepted `i_valid`.
  - With `i_num_tri`=0, `o_valid` is asserted 1 cycle after `i_start`.
- **Output hold:** `o_hit`/`o_t`/`o_tri_id` hold their value after the pulse until the next `o_valid`.
- **Throughput:**
  - One response per cycle; back-to-back `i_valid` is fully supported.
  - The earliest next `i_start` is the cycle after `o_valid`. Minimum ray turnaround is `i_num_tri`+2 cycles.
- No backpressure: the block is always ready in `ACCUM`.

## Structure

- Shared package `raytrace_pkg`:
  - `typedef logic signed [31:0] fixed_t`
  - `localparam FRAC_BITS = 16`
  - `localparam fixed_t T_INF = 32'sh7FFF_FFFF` (this is the default for `T_MAX`)
  - state enum `hit_state_e`
- No sub-module: a single FSM plus one signed comparator.

## Test plan

1. **Single hit:** reset, start with `i_num_tri`=1, one response with `i_result`=1 and `i_t`=180224 (2.75) → `o_valid` 1 cycle later, `o_hit`=1, `o_t`=180224, `o_tri_id`=0.
2. **Nearest of several:** start with count 4; back-to-back responses (hit 0x50000), (miss), (hit 0x30000), (hit 0x40000) → `o_t`=0x30000, `o_tri_id`=2, `o_valid` exactly 1 cycle after the 4th response.
3. **Tie:** start with count 3; responses hit 0x20000, hit 0x20000, miss → `o_tri_id`=0.
4. **All miss and zero count:**
   - Count 3 with all misses → `o_hit`=0, `o_t`=0x7FFFFFFF, `o_tri_id`=0.
   - Count 0 → `o_valid` 1 cycle after `i_start`, and `o_busy` never asserts.
5. **Ignored inputs:**
   - `i_valid` while `IDLE` → no state change.
   - `i_start` during `ACCUM` → the count is not reloaded, and the result matches the original ray.
   - Gapped `i_valid` (idle cycles between responses) gives the same result as back-to-back.
6. **Reset mid-ray:** assert `i_rst` after 2 of 5 responses → outputs return to their reset values, no `o_valid`; a fresh ray afterwards completes correctly.
